// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Function : Measures high time and period of a PWM line, recovers its 3-bit
//            duty code and flags a line with no rising edges.
// Revision : 1.0
// ============================================================================
module pwm_capture #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [2:0]       duty_code,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stuck,
    output logic             overrun
);
    localparam int               RW        = CNT_W + 2;
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic             sync1_q, lvl_q, lvl_dly_q;
    logic [CNT_W-1:0] per_q, hi_q, sh_per_q, sh_hi_q;
    logic [RW-1:0]    rem_q;
    logic [1:0]       quo_q;
    logic [1:0]       step_q;
    logic             busy_q;
    logic [2:0]       duty_q;
    logic [CNT_W-1:0] high_q, period_q;
    logic             meas_valid_q, stuck_q, overrun_q;

    logic             rise;
    logic [CNT_W-1:0] per_inc;
    logic             timeout_hit;
    logic [RW-1:0]    rem_sh, rem_d, per_ext;
    logic             bit_d;

    assign rise        = lvl_q & ~lvl_dly_q;
    assign per_inc     = per_q + 1'b1;
    assign timeout_hit = (per_q != C_TIMEOUT) && (per_inc == C_TIMEOUT);

    // One restoring-division step per cycle; hi < per keeps the quotient in 3 bits.
    always_comb begin
        per_ext = {2'b00, sh_per_q};
        rem_sh  = rem_q << 1;
        bit_d   = (rem_sh >= per_ext);
        rem_d   = bit_d ? (rem_sh - per_ext) : rem_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            lvl_q        <= 1'b0;
            lvl_dly_q    <= 1'b0;
            per_q        <= '0;
            hi_q         <= '0;
            sh_per_q     <= '0;
            sh_hi_q      <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            step_q       <= '0;
            busy_q       <= 1'b0;
            duty_q       <= '0;
            high_q       <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            stuck_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= pwm_in;
            lvl_q        <= sync1_q;
            lvl_dly_q    <= lvl_q;
            meas_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            if (!en) begin
                state_q  <= IDLE;
                per_q    <= '0;
                hi_q     <= '0;
                busy_q   <= 1'b0;
                step_q   <= '0;
                duty_q   <= '0;
                high_q   <= '0;
                period_q <= '0;
                stuck_q  <= 1'b0;
            end else begin
                if (busy_q) begin
                    rem_q  <= rem_d;
                    quo_q  <= {quo_q[0], bit_d};
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd2) begin
                        busy_q       <= 1'b0;
                        step_q       <= '0;
                        duty_q       <= {quo_q, bit_d};
                        high_q       <= sh_hi_q;
                        period_q     <= sh_per_q;
                        meas_valid_q <= 1'b1;
                    end
                end
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            per_q   <= CNT_W'(1);
                            hi_q    <= CNT_W'(1);
                            state_q <= RUN;
                        end else if (per_q != C_TIMEOUT) begin
                            per_q <= per_inc;
                            if (timeout_hit) begin
                                meas_valid_q <= ~stuck_q;
                                stuck_q      <= 1'b1;
                                duty_q       <= lvl_q ? 3'd7 : 3'd0;
                                high_q       <= '0;
                                period_q     <= '0;
                            end
                        end
                    end
                    RUN: begin
                        if (rise) begin
                            per_q <= CNT_W'(1);
                            hi_q  <= CNT_W'(1);
                            if (busy_q) begin
                                overrun_q <= 1'b1;
                            end else begin
                                sh_per_q <= per_q;
                                sh_hi_q  <= hi_q;
                                rem_q    <= {2'b00, hi_q};
                                quo_q    <= '0;
                                step_q   <= '0;
                                busy_q   <= 1'b1;
                                stuck_q  <= 1'b0;
                            end
                        end else if (timeout_hit) begin
                            per_q        <= per_inc;
                            state_q      <= IDLE;
                            meas_valid_q <= ~stuck_q;
                            stuck_q      <= 1'b1;
                            duty_q       <= lvl_q ? 3'd7 : 3'd0;
                            high_q       <= '0;
                            period_q     <= '0;
                        end else begin
                            per_q <= per_inc;
                            hi_q  <= hi_q + {{(CNT_W-1){1'b0}}, lvl_q};
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign duty_code  = duty_q;
    assign high_cnt   = high_q;
    assign period_cnt = period_q;
    assign meas_valid = meas_valid_q;
    assign stuck      = stuck_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_capture
// Function : Directed scoreboard bench for pwm_capture.
// Revision : 1.0
// ============================================================================
module tb_pwm_capture;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 64;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             pwm_in;
    logic [2:0]       duty_code;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             stuck;
    logic             overrun;

    typedef struct {
        logic [2:0]       duty;
        logic [CNT_W-1:0] hi;
        logic [CNT_W-1:0] per;
        logic             stk;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks   = 0;
    int   errors   = 0;
    int   ovr_cnt  = 0;
    int   meas_idx = 0;

    pwm_capture #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pwm_in    (pwm_in),
        .duty_code (duty_code),
        .high_cnt  (high_cnt),
        .period_cnt(period_cnt),
        .meas_valid(meas_valid),
        .stuck     (stuck),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every reported measurement must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && meas_valid) begin
                checks++;
                meas_idx++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL meas#%0d unexpected: got duty=%0d high=%0d period=%0d stuck=%0d, none expected",
                             meas_idx, duty_code, high_cnt, period_cnt, stuck);
                end else begin
                    e = exp_q.pop_front();
                    if (duty_code !== e.duty || high_cnt !== e.hi || period_cnt !== e.per || stuck !== e.stk) begin
                        errors++;
                        $display("FAIL meas#%0d: got duty=%0d high=%0d period=%0d stuck=%0d, expected duty=%0d high=%0d period=%0d stuck=%0d",
                                 meas_idx, duty_code, high_cnt, period_cnt, stuck, e.duty, e.hi, e.per, e.stk);
                    end
                end
            end
            if (rst_n && overrun) ovr_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push(input int duty, input int hi, input int per, input int stk, input int n);
        exp_t x;
        x.duty = 3'(duty);
        x.hi   = CNT_W'(hi);
        x.per  = CNT_W'(per);
        x.stk  = 1'(stk);
        for (int k = 0; k < n; k++) exp_q.push_back(x);
    endtask

    task automatic pwm_periods(input int hi, input int per, input int n);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < per; c++) begin
                pwm_in = (c < hi);
                @(negedge clk);
            end
        end
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic en_pulse_low();
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
    endtask

    initial begin
        // Reset state, then a line held low goes stuck
        rst_n  = 1'b0;
        en     = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_duty", duty_code, 0);
        chk("rst_high", high_cnt, 0);
        chk("rst_period", period_cnt, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_stuck", stuck, 0);
        chk("rst_overrun", overrun, 0);
        push(0, 0, 0, 1, 1);
        rst_n = 1'b1;
        repeat (TIMEOUT - 4) @(negedge clk);
        chk("stuck_early", stuck, 0);
        repeat (10) @(negedge clk);
        chk("stuck_low", stuck, 1);
        chk("stuck_low_duty", duty_code, 0);
        drain("drain_t1");

        // Loopback duty 3 then duty 5, then line held high
        push(3, 3, 8, 0, 4);
        push(5, 5, 8, 0, 3);
        push(7, 0, 0, 1, 1);
        pwm_periods(3, 8, 4);
        pwm_periods(5, 8, 3);
        pwm_in = 1'b1;
        repeat (100) @(negedge clk);
        chk("stuck_high", stuck, 1);
        chk("stuck_high_duty", duty_code, 7);
        drain("drain_t3a");

        // Restart: first rise in IDLE keeps stuck, second capture clears it
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        push(5, 5, 8, 0, 2);
        pwm_periods(5, 8, 1);
        chk("stuck_hold", stuck, 1);
        pwm_periods(5, 8, 2);
        chk("stuck_clear", stuck, 0);
        drain("drain_t3b");
        chk("restart_duty", duty_code, 5);
        en_pulse_low();

        // External PWM 13 of 20
        push(5, 13, 20, 0, 2);
        pwm_periods(13, 20, 3);
        drain("drain_t4");
        chk("ext_high", high_cnt, 13);
        chk("ext_period", period_cnt, 20);
        en_pulse_low();

        // Period-3 pulses overrun every other period, then period 10 with 5 high
        ovr_cnt = 0;
        push(2, 1, 3, 0, 3);
        push(4, 5, 10, 0, 2);
        pwm_periods(1, 3, 6);
        pwm_periods(5, 10, 3);
        drain("drain_t5");
        chk("overrun_count", ovr_cnt, 3);
        en_pulse_low();

        // en dropped mid-period clears outputs
        push(3, 3, 8, 0, 2);
        pwm_periods(3, 8, 3);
        drain("drain_t6a");
        en = 1'b0;
        @(negedge clk);
        chk("en_low_duty", duty_code, 0);
        chk("en_low_high", high_cnt, 0);
        chk("en_low_period", period_cnt, 0);
        en = 1'b1;
        push(3, 3, 8, 0, 2);
        pwm_periods(3, 8, 3);
        drain("drain_t6b");

        // Asynchronous reset while a divide is in flight
        pwm_in = 1'b1;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_duty", duty_code, 0);
        chk("async_high", high_cnt, 0);
        chk("async_period", period_cnt, 0);
        chk("async_valid", meas_valid, 0);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push(3, 3, 8, 0, 2);
        pwm_periods(3, 8, 3);
        drain("drain_t6c");
        repeat (10) @(negedge clk);
        chk("final_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
